alu: RTL and testbench

//   32-bit integer ALU for the EX stage of the 5-stage MIPS pipeline.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_shifter.sv | 37 +++
 rtl/alu.sv | 86 ++++++++
 tb/tb_alu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and datapath width, imported by
// the ALU, the ID-stage decoder and the forwarding logic.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd5;
  localparam logic [4:0] ALU_ANDI = 5'd6;
  localparam logic [4:0] ALU_XORI = 5'd7;
  localparam logic [4:0] ALU_ORI  = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd16;
  localparam logic [4:0] ALU_SRL  = 5'd17;
  localparam logic [4:0] ALU_SRA  = 5'd18;
  localparam logic [4:0] ALU_SLT  = 5'd19;
  localparam logic [4:0] ALU_SLTU = 5'd20;

  typedef enum logic [1:0] {
    SHIFT_LL = 2'd0,
    SHIFT_RL = 2'd1,
    SHIFT_RA = 2'd2
  } shift_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Five-stage logarithmic barrel shifter. Left shifts reuse the right-shift
// network by bit-reversing the operand on the way in and out.
module alu_shifter #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [4:0]         amount,
  input  alu_pkg::shift_op_t op,
  output logic [WIDTH-1:0]   result
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] ONES = '1;

  logic             fill;
  logic [WIDTH-1:0] stage;

  always_comb begin
    fill   = (op == SHIFT_RA) && data[WIDTH-1];
    stage  = data;
    result = '0;
    if (op == SHIFT_LL) begin
      for (int unsigned i = 0; i < WIDTH; i++) stage[i] = data[WIDTH-1-i];
    end
    // Each stage shifts by 2^s and ORs in the vacated sign bits for sra.
    for (int unsigned s = 0; s < 5; s++) begin
      if (amount[s]) begin
        stage = (stage >> (1 << s)) | (fill ? ~(ONES >> (1 << s)) : '0);
      end
    end
    result = stage;
    if (op == SHIFT_LL) begin
      for (int unsigned i = 0; i < WIDTH; i++) result[i] = stage[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/alu.sv
// EX-stage integer ALU: combinational operation select feeding a single
// output register (one cycle latency, synchronous active-low reset).
module alu #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ALUCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow
);
  import alu_pkg::*;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_result;
  logic             next_ovf;
  shift_op_t        sh_op;

  assign sum  = A + B;
  assign diff = A - B;
  assign imm  = {{(WIDTH-16){1'b0}}, B[15:0]};

  always_comb begin
    case (ALUCode)
      ALU_SRL: sh_op = SHIFT_RL;
      ALU_SRA: sh_op = SHIFT_RA;
      default: sh_op = SHIFT_LL;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data   (B),
    .amount (A[4:0]),
    .op     (sh_op),
    .result (shifted)
  );

  always_comb begin
    next_result = '0;
    next_ovf    = 1'b0;
    case (ALUCode)
      ALU_ADD: begin
        next_result = sum;
        next_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        next_result = diff;
        next_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND:  next_result = A & B;
      ALU_XOR:  next_result = A ^ B;
      ALU_OR:   next_result = A | B;
      ALU_NOR:  next_result = ~(A | B);
      ALU_ANDI: next_result = A & imm;
      ALU_XORI: next_result = A ^ imm;
      ALU_ORI:  next_result = A | imm;
      ALU_SLL, ALU_SRL, ALU_SRA: next_result = shifted;
      // Direct signed compare; the sign of A-B is wrong when A-B overflows.
      ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: next_result = {{(WIDTH-1){1'b0}}, (A < B)};
      default: begin
        next_result = '0;
        next_ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      ALUResult <= next_result;
      Zero      <= (next_result == '0);
      Overflow  <= next_ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ALUCode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALUCode   (ALUCode),
    .A         (A),
    .B         (B),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed arithmetic decides overflow by range.
  function automatic void model(input logic [4:0] c, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r,
                                output logic v);
    longint sx  = longint'($signed(x));
    longint sy  = longint'($signed(y));
    longint lim = 64'sh7FFF_FFFF;
    longint s;
    r = '0;
    v = 1'b0;
    case (c)
      5'd0:  begin s = sx + sy; r = s[31:0]; v = (s > lim) || (s < -lim - 1); end
      5'd5:  begin s = sx - sy; r = s[31:0]; v = (s > lim) || (s < -lim - 1); end
      5'd1:  r = x & y;
      5'd2:  r = x ^ y;
      5'd3:  r = x | y;
      5'd4:  r = ~(x | y);
      5'd6:  r = x & {16'h0, y[15:0]};
      5'd7:  r = x ^ {16'h0, y[15:0]};
      5'd8:  r = x | {16'h0, y[15:0]};
      5'd16: r = y << x[4:0];
      5'd17: r = y >> x[4:0];
      5'd18: r = 32'($signed(y) >>> x[4:0]);
      5'd19: r = {31'b0, (sx < sy)};
      5'd20: r = {31'b0, (x < y)};
      default: r = '0;
    endcase
  endfunction

  task automatic step(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    ALUCode = c;
    A       = x;
    B       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(5'd0, 32'h4000_0000, 32'h4000_0000 + $urandom_range(1, 255));
      checks++;
      if (ALUResult !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: got res=%h z=%b ov=%b want res=0 z=1 ov=0",
                 i, ALUResult, Zero, Overflow);
      end
    end
    rst_n = 1'b1;
    step(5'd0, 32'h0000_0003, 32'h0000_0004);
    checks++;
    if (ALUResult !== 32'h7 || Zero !== 1'b0 || Overflow !== 1'b0) begin
      failures++;
      $display("FAIL first_after_reset: got res=%h z=%b ov=%b want res=7 z=0 ov=0",
               ALUResult, Zero, Overflow);
    end
  endtask

  task automatic test_arith();
    logic [4:0]  tc [4] = '{5'd0, 5'd0, 5'd5, 5'd5};
    logic [31:0] ta [4] = '{32'h4000_0000, 32'h0000_4012, 32'h70F0_C0E0, 32'h5};
    logic [31:0] tb [4] = '{32'h4000_0000, 32'h1000_200F, 32'h1000_3054, 32'h5};
    logic [31:0] er [4] = '{32'h8000_0000, 32'h1000_6021, 32'h60F0_908C, 32'h0};
    logic        eo [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(tc[i], ta[i], tb[i]);
      checks++;
      if (ALUResult !== er[i] || Overflow !== eo[i] || Zero !== (er[i] == 32'h0)) begin
        failures++;
        $display("FAIL arith[%0d]: got res=%h z=%b ov=%b want res=%h z=%b ov=%b",
                 i, ALUResult, Zero, Overflow, er[i], (er[i] == 32'h0), eo[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [4:0]  tc [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8};
    logic [31:0] tb [7] = '{32'h10DF_30FF, 32'h10DF_30FF, 32'h10DF_30FF, 32'h10DF_30FF,
                            32'hFFFF_E0FF, 32'hFFFF_E0FF, 32'hFFFF_E0FF};
    logic [31:0] er [7] = '{32'h100C_0010, 32'hEFD3_3EEF, 32'hFFDF_3EFF, 32'h0020_C100,
                            32'h0000_0010, 32'hFF0C_EEEF, 32'hFF0C_EEFF};
    for (int i = 0; i < 7; i++) begin
      step(tc[i], 32'hFF0C_0E10, tb[i]);
      checks++;
      if (ALUResult !== er[i] || Overflow !== 1'b0 || Zero !== 1'b0) begin
        failures++;
        $display("FAIL logic[code %0d]: got res=%h z=%b ov=%b want res=%h z=0 ov=0",
                 tc[i], ALUResult, Zero, Overflow, er[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [4:0]  tc [8] = '{5'd16, 5'd17, 5'd18, 5'd16, 5'd17, 5'd18, 5'd16, 5'd18};
    logic [31:0] ta [8] = '{32'h4, 32'h4, 32'h4, 32'hFFFF_FFE4, 32'hFFFF_FFE4,
                            32'hFFFF_FFE4, 32'h0, 32'hFFFF_FFE0};
    logic [31:0] er [8] = '{32'hFFFE_0FF0, 32'h0FFF_FE0F, 32'hFFFF_FE0F, 32'hFFFE_0FF0,
                            32'h0FFF_FE0F, 32'hFFFF_FE0F, 32'hFFFF_E0FF, 32'hFFFF_E0FF};
    for (int i = 0; i < 8; i++) begin
      step(tc[i], ta[i], 32'hFFFF_E0FF);
      checks++;
      if (ALUResult !== er[i] || Overflow !== 1'b0) begin
        failures++;
        $display("FAIL shift[%0d code %0d]: got res=%h ov=%b want res=%h ov=0",
                 i, tc[i], ALUResult, Overflow, er[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [4:0]  tc [4] = '{5'd19, 5'd20, 5'd19, 5'd20};
    logic [31:0] ta [4] = '{32'hFF00_0004, 32'hFF00_0004, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'h7000_00FF, 32'h7000_00FF, 32'h0000_0001, 32'h0000_0001};
    logic [31:0] er [4] = '{32'h1, 32'h0, 32'h1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      step(tc[i], ta[i], tb[i]);
      checks++;
      if (ALUResult !== er[i] || Zero !== (er[i] == 32'h0) || Overflow !== 1'b0) begin
        failures++;
        $display("FAIL compare[%0d]: got res=%h z=%b ov=%b want res=%h",
                 i, ALUResult, Zero, Overflow, er[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] tc [4] = '{5'd9, 5'd15, 5'd21, 5'd31};
    for (int i = 0; i < 4; i++) begin
      step(tc[i], $urandom | 32'h1, $urandom | 32'h8000_0000);
      checks++;
      if (ALUResult !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
        failures++;
        $display("FAIL illegal[code %0d]: got res=%h z=%b ov=%b want res=0 z=1 ov=0",
                 tc[i], ALUResult, Zero, Overflow);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] er;
    logic        eo;
    logic [4:0]  c;
    logic [31:0] x, y;
    for (int i = 0; i < 300; i++) begin
      c = 5'($urandom_range(0, 31));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = {x[31], {31{x[30]}}} ^ 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) y = x;
      model(c, x, y, er, eo);
      step(c, x, y);
      checks++;
      if (ALUResult !== er || Overflow !== eo || Zero !== (er == 32'h0)) begin
        failures++;
        $display("FAIL random[%0d code %0d A=%h B=%h]: got res=%h z=%b ov=%b want res=%h z=%b ov=%b",
                 i, c, x, y, ALUResult, Zero, Overflow, er, (er == 32'h0), eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_r, er;
    logic        prev_v, eo;
    logic [4:0]  c;
    logic [31:0] x, y;
    @(negedge clk);
    c = 5'd0; x = 32'h7FFF_FFFF; y = 32'h1;
    ALUCode = c; A = x; B = y;
    model(c, x, y, prev_r, prev_v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (ALUResult !== prev_r || Overflow !== prev_v || Zero !== (prev_r == 32'h0)) begin
        failures++;
        $display("FAIL b2b[%0d]: got res=%h z=%b ov=%b want res=%h ov=%b",
                 i, ALUResult, Zero, Overflow, prev_r, prev_v);
      end
      c = (i % 2 == 0) ? 5'(16 + (i % 5)) : 5'(i % 9);
      x = $urandom;
      y = $urandom;
      ALUCode = c; A = x; B = y;
      model(c, x, y, er, eo);
      #1;
      checks++;
      if (ALUResult !== prev_r || Overflow !== prev_v) begin
        failures++;
        $display("FAIL b2b_hold[%0d]: got res=%h ov=%b before edge, want res=%h ov=%b",
                 i, ALUResult, Overflow, prev_r, prev_v);
      end
      prev_r = er;
      prev_v = eo;
    end
    @(negedge clk);
    checks++;
    if (ALUResult !== prev_r || Overflow !== prev_v) begin
      failures++;
      $display("FAIL b2b_last: got res=%h ov=%b want res=%h ov=%b",
               ALUResult, Overflow, prev_r, prev_v);
    end
  endtask

  task automatic test_reset_dominance();
    @(negedge clk);
    rst_n   = 1'b0;
    ALUCode = 5'd3;
    A       = 32'hFFFF_FFFF;
    B       = 32'h1234_5678;
    @(posedge clk);
    #1;
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_dominance: got res=%h z=%b ov=%b want res=0 z=1 ov=0",
               ALUResult, Zero, Overflow);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ALUCode = 5'($urandom);
    A       = $urandom;
    B       = $urandom;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_dominance();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
